// File: rtl/pico_ahb_pkg.sv
// Shared AHB encodings, slave FSM states and byte-lane helpers for the PicoRV32 SRAM window.
package pico_ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'b000,
        HSIZE_HALF = 3'b001,
        HSIZE_WORD = 3'b010
    } hsize_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01
    } hresp_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_e;

    // Big-endian lanes: mask bit 3 enables HWDATA[31:24], bit 0 enables HWDATA[7:0].
    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] a);
        case (size)
            HSIZE_BYTE: lane_mask = 4'b1000 >> a;
            HSIZE_HALF: lane_mask = a[1] ? 4'b0011 : 4'b1100;
            HSIZE_WORD: lane_mask = 4'b1111;
            default:    lane_mask = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] lane_expand(input logic [3:0] m);
        for (int i = 0; i < 4; i++) begin
            lane_expand[8*i +: 8] = {8{m[i]}};
        end
    endfunction

endpackage

// File: rtl/pico_ahb_sram_slave_if.sv
// AHB-lite slave-side bundle between the PicoRV32 master/bus fabric and the SRAM slave.
interface pico_ahb_sram_slave_if;
    // An address phase is taken when HSEL & HREADY & HTRANS[1]; HREADYOUT=0 stretches the
    // current data phase, and HWDATA/HRDATA are only meaningful in the cycle HREADYOUT=1.
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic [1:0]  HRESP;
    logic [31:0] HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA, HREADY,
        input  HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/pico_sram_bank.sv
// Simple dual-port synchronous RAM: one byte-enabled write port, one registered read port.
module pico_sram_bank #(
    parameter int WORDS = 4096,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [3:0]    wbe,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [WORDS];
    logic [31:0] rdata_d, rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (wbe[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Read register holds between reads so the bus sees stable HRDATA.
    always_comb begin
        rdata_d = rdata_q;
        if (re) rdata_d = mem[raddr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata_q <= '0;
        else        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/pico_ahb_sram_slave.sv
// AHB SRAM slave: decodes beats, inserts wait states, returns two-cycle ERROR on bad accesses.
module pico_ahb_sram_slave
    import pico_ahb_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = 32'h4000_0000,
    parameter int          MEM_WORDS   = 4096,
    parameter int          WAIT_STATES = 0
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    pico_ahb_sram_slave_if.slave ahb,
    output state_e               dbg_state
);

    localparam int          AW   = $clog2(MEM_WORDS);
    localparam logic [31:0] SPAN = 32'(MEM_WORDS * 4);
    localparam logic [1:0]  WS   = 2'(WAIT_STATES);

    state_e        state_d, state_q;
    logic [1:0]    cnt_d, cnt_q;
    logic          wr_d, wr_q;
    logic [AW-1:0] idx_d, idx_q;
    logic [3:0]    mask_d, mask_q;
    logic [3:0]    byp_mask_d, byp_mask_q;
    logic [31:0]   byp_data_d, byp_data_q;

    logic [31:0]   off;
    logic [AW-1:0] word_idx;
    logic          accept, addr_err;
    logic [1:0]    cnt_inc;
    logic          rd_en, wr_en, byp_hit;
    logic [AW-1:0] rd_idx;
    logic [31:0]   ram_rdata, byp_lanes;
    logic          unused_bits;

    assign off      = ahb.HADDR - ADDR_BASE;
    assign word_idx = off[AW+1:2];
    assign accept   = ahb.HSEL & ahb.HREADY &
                      ((ahb.HTRANS == HTRANS_NONSEQ) || (ahb.HTRANS == HTRANS_SEQ));
    assign cnt_inc  = cnt_q + 2'd1;

    // Unsigned offset compare also rejects addresses below the base.
    always_comb begin
        addr_err = 1'b0;
        if (ahb.HSIZE > HSIZE_WORD)                          addr_err = 1'b1;
        if ((ahb.HSIZE == HSIZE_HALF) && ahb.HADDR[0])       addr_err = 1'b1;
        if ((ahb.HSIZE == HSIZE_WORD) && (ahb.HADDR[1:0] != 2'b00)) addr_err = 1'b1;
        if (off >= SPAN)                                     addr_err = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        idx_d   = idx_q;
        mask_d  = mask_q;
        rd_en   = 1'b0;
        rd_idx  = idx_q;
        case (state_q)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                state_d = ST_IDLE;
                wr_d    = 1'b0;
                cnt_d   = '0;
                if (accept) begin
                    if (addr_err) begin
                        state_d = ST_ERR1;
                    end else begin
                        wr_d   = ahb.HWRITE;
                        idx_d  = word_idx;
                        mask_d = lane_mask(ahb.HSIZE, ahb.HADDR[1:0]);
                        if (WAIT_STATES == 0) begin
                            // Zero-wait reads sample the array at the end of the address phase.
                            state_d = ST_DATA;
                            rd_en   = ~ahb.HWRITE;
                            rd_idx  = word_idx;
                        end else begin
                            state_d = ST_WAIT;
                        end
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_inc;
                if (cnt_inc == WS) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                    rd_en   = ~wr_q;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase
    end

    // A write commits on the edge ending DATA; a read on that same edge sees its lanes.
    assign wr_en   = (state_q == ST_DATA) & wr_q;
    assign byp_hit = wr_en & rd_en & (idx_q == rd_idx);

    always_comb begin
        byp_mask_d = byp_mask_q;
        byp_data_d = byp_data_q;
        if (rd_en) begin
            byp_mask_d = byp_hit ? mask_q : 4'b0000;
            byp_data_d = ahb.HWDATA;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            wr_q       <= 1'b0;
            idx_q      <= '0;
            mask_q     <= '0;
            byp_mask_q <= '0;
            byp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_q       <= wr_d;
            idx_q      <= idx_d;
            mask_q     <= mask_d;
            byp_mask_q <= byp_mask_d;
            byp_data_q <= byp_data_d;
        end
    end

    pico_sram_bank #(
        .WORDS (MEM_WORDS),
        .AW    (AW)
    ) u_bank (
        .clk   (HCLK),
        .rst_n (HRESETn),
        .we    (wr_en),
        .waddr (idx_q),
        .wbe   (mask_q),
        .wdata (ahb.HWDATA),
        .re    (rd_en),
        .raddr (rd_idx),
        .rdata (ram_rdata)
    );

    assign byp_lanes     = lane_expand(byp_mask_q);
    assign ahb.HRDATA    = (ram_rdata & ~byp_lanes) | (byp_data_q & byp_lanes);
    assign ahb.HREADYOUT = !((state_q == ST_WAIT) || (state_q == ST_ERR1));
    assign ahb.HRESP     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    assign dbg_state     = state_q;

    assign unused_bits = ^{ahb.HBURST, ahb.HPROT};

endmodule

// File: tb/tb_pico_ahb_sram_slave.sv
// Directed bench for pico_ahb_sram_slave: one zero-wait and one two-wait instance on a shared bus.
module tb_pico_ahb_sram_slave;
    import pico_ahb_pkg::*;

    localparam int EXP_W = 36;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cur;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;

    int checks = 0;
    int errors = 0;
    logic [EXP_W-1:0] exp_q[$];

    state_e dbg0, dbg2;
    logic        cur_ready;
    logic [1:0]  cur_resp;
    logic [31:0] cur_rdata;

    pico_ahb_sram_slave_if bus0 ();
    pico_ahb_sram_slave_if bus2 ();

    always #5 clk = ~clk;

    assign bus0.HSEL   = hsel & ~cur;
    assign bus0.HADDR  = haddr;
    assign bus0.HTRANS = htrans;
    assign bus0.HWRITE = hwrite;
    assign bus0.HSIZE  = hsize;
    assign bus0.HBURST = 3'b001;
    assign bus0.HPROT  = 4'b0011;
    assign bus0.HWDATA = hwdata;
    assign bus0.HREADY = bus0.HREADYOUT;

    assign bus2.HSEL   = hsel & cur;
    assign bus2.HADDR  = haddr;
    assign bus2.HTRANS = htrans;
    assign bus2.HWRITE = hwrite;
    assign bus2.HSIZE  = hsize;
    assign bus2.HBURST = 3'b001;
    assign bus2.HPROT  = 4'b0011;
    assign bus2.HWDATA = hwdata;
    assign bus2.HREADY = bus2.HREADYOUT;

    assign cur_ready = cur ? bus2.HREADYOUT : bus0.HREADYOUT;
    assign cur_resp  = cur ? bus2.HRESP     : bus0.HRESP;
    assign cur_rdata = cur ? bus2.HRDATA    : bus0.HRDATA;

    pico_ahb_sram_slave #(
        .ADDR_BASE   (32'h4000_0000),
        .MEM_WORDS   (4096),
        .WAIT_STATES (0)
    ) u_dut0 (
        .HCLK      (clk),
        .HRESETn   (rst_n),
        .ahb       (bus0.slave),
        .dbg_state (dbg0)
    );

    pico_ahb_sram_slave #(
        .ADDR_BASE   (32'h4000_0000),
        .MEM_WORDS   (4096),
        .WAIT_STATES (2)
    ) u_dut2 (
        .HCLK      (clk),
        .HRESETn   (rst_n),
        .ahb       (bus2.slave),
        .dbg_state (dbg2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: tracks data phases on its own and pops one expectation per completed beat.
    bit          dp_active = 1'b0;
    int          stall_cnt = 0;
    logic [1:0]  stall_resp = 2'b00;
    logic [EXP_W-1:0] e;

    always @(negedge clk) begin
        if (!rst_n) begin
            dp_active = 1'b0;
        end else begin
            if (dp_active) begin
                if (!cur_ready) begin
                    stall_cnt++;
                    stall_resp = cur_resp;
                end else begin
                    dp_active = 1'b0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat actual=completion required=none at %0t", $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk("stall_cycles", 32'(stall_cnt), 32'(e[33:32]));
                        chk("hresp", 32'(cur_resp), e[34] ? 32'd1 : 32'd0);
                        if (e[33:32] != 2'd0) chk("hresp_stall", 32'(stall_resp), e[34] ? 32'd1 : 32'd0);
                        if (e[35] && !e[34]) chk("hrdata", cur_rdata, e[31:0]);
                    end
                end
            end
            if (hsel && htrans[1] && cur_ready) begin
                dp_active  = 1'b1;
                stall_cnt  = 0;
                stall_resp = 2'b00;
            end
        end
    end

    task automatic beat(input logic [31:0] addr, input logic [2:0] size, input logic wr,
                        input logic seq, input logic [31:0] wdata, input logic err,
                        input logic [31:0] rdata);
        logic [1:0] waits;
        int n;
        waits  = err ? 2'd1 : (cur ? 2'd2 : 2'd0);
        haddr  = addr;
        hsize  = size;
        hwrite = wr;
        htrans = seq ? HTRANS_SEQ : HTRANS_NONSEQ;
        hsel   = 1'b1;
        exp_q.push_back({~wr, err, waits, rdata});
        n = 0;
        @(negedge clk);
        while (!cur_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!cur_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=stalled required=ready addr=%h", addr);
        end
        @(posedge clk);
        #1;
        hwdata = wdata;
    endtask

    task automatic wr(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d, input logic seq);
        beat(a, s, 1'b1, seq, d, 1'b0, 32'h0);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] d, input logic seq);
        beat(a, HSIZE_WORD, 1'b0, seq, 32'h0, 1'b0, d);
    endtask

    task automatic bad(input logic [31:0] a, input logic [2:0] s);
        beat(a, s, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 32'h0);
    endtask

    task automatic idle(input int n);
        hsel   = 1'b0;
        htrans = HTRANS_IDLE;
        hwrite = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n  = 1'b0;
        cur    = 1'b0;
        hsel   = 1'b0;
        htrans = HTRANS_IDLE;
        hwrite = 1'b0;
        hsize  = HSIZE_WORD;
        haddr  = 32'h0;
        hwdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hreadyout0", 32'(bus0.HREADYOUT), 32'd1);
        chk("rst_hresp0",     32'(bus0.HRESP),     32'd0);
        chk("rst_hrdata0",    bus0.HRDATA,         32'h0);
        chk("rst_state0",     32'(dbg0),           32'(ST_IDLE));
        chk("rst_hreadyout2", 32'(bus2.HREADYOUT), 32'd1);
        chk("rst_hrdata2",    bus2.HRDATA,         32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Zero-wait instance: word, byte and halfword lanes.
        cur = 1'b0;
        wr(32'h4000_0010, HSIZE_WORD, 32'hDEAD_BEEF, 1'b0); idle(2);
        rd(32'h4000_0010, 32'hDEAD_BEEF, 1'b0);             idle(2);
        wr(32'h4000_0010, HSIZE_WORD, 32'h1122_3344, 1'b0);
        wr(32'h4000_0013, HSIZE_BYTE, 32'h5A5A_5AAA, 1'b1); idle(2);
        rd(32'h4000_0010, 32'h1122_33AA, 1'b0);             idle(2);
        wr(32'h4000_0010, HSIZE_HALF, 32'h5566_9999, 1'b0); idle(2);
        rd(32'h4000_0010, 32'h5566_33AA, 1'b0);             idle(2);

        // Write immediately followed by read of the same word: full and partial bypass.
        wr(32'h4000_0020, HSIZE_WORD, 32'hCAFE_F00D, 1'b0);
        rd(32'h4000_0020, 32'hCAFE_F00D, 1'b0);             idle(2);
        wr(32'h4000_0024, HSIZE_WORD, 32'h0102_0304, 1'b0); idle(2);
        wr(32'h4000_0026, HSIZE_HALF, 32'h7777_BEEF, 1'b0);
        rd(32'h4000_0024, 32'h0102_BEEF, 1'b0);             idle(2);

        // Error responses; the aliasing indices must remain untouched.
        wr(32'h4000_0000, HSIZE_WORD, 32'h1357_9BDF, 1'b0);
        wr(32'h4000_3FFC, HSIZE_WORD, 32'h0F0F_0F0F, 1'b0); idle(2);
        bad(32'h4000_0002, HSIZE_WORD);
        bad(32'h4000_0001, HSIZE_HALF);
        bad(32'h3FFF_FFFC, HSIZE_WORD);
        bad(32'h4000_4000, HSIZE_WORD);
        bad(32'h4000_0000, 3'b011);
        rd(32'h4000_0000, 32'h1357_9BDF, 1'b0);
        rd(32'h4000_3FFC, 32'h0F0F_0F0F, 1'b0);             idle(3);

        // Two-wait instance: pipelined writes, error, four-beat incrementing read.
        cur = 1'b1;
        wr(32'h4000_0100, HSIZE_WORD, 32'hA000_0001, 1'b0);
        wr(32'h4000_0104, HSIZE_WORD, 32'hA000_0002, 1'b1);
        wr(32'h4000_0108, HSIZE_WORD, 32'hA000_0003, 1'b1);
        wr(32'h4000_010C, HSIZE_WORD, 32'hA000_0004, 1'b1); idle(4);
        bad(32'h4000_0102, HSIZE_WORD);
        rd(32'h4000_0100, 32'hA000_0001, 1'b0);
        rd(32'h4000_0104, 32'hA000_0002, 1'b1);
        rd(32'h4000_0108, 32'hA000_0003, 1'b1);
        rd(32'h4000_010C, 32'hA000_0004, 1'b1);             idle(4);

        // Reset lands while a write is in its wait cycles.
        haddr  = 32'h4000_0100;
        hsize  = HSIZE_WORD;
        hwrite = 1'b1;
        htrans = HTRANS_NONSEQ;
        hsel   = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        hsel   = 1'b0;
        htrans = HTRANS_IDLE;
        hwrite = 1'b0;
        hwdata = 32'hFFFF_0000;
        chk("pre_rst_stall", 32'(bus2.HREADYOUT), 32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_hreadyout", 32'(bus2.HREADYOUT), 32'd1);
        chk("mid_rst_hrdata",    bus2.HRDATA,         32'h0);
        chk("mid_rst_hresp",     32'(bus2.HRESP),     32'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);
        rd(32'h4000_0100, 32'hA000_0001, 1'b0);             idle(4);

        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
